bram_prog_loader: RTL and testbench

- Boot/program-load sequencer for the unified instruction/data BRAM of the single-core RISC-V system.
- Owns the core reset and arbitrates BRAM data port A between the core's dmem interface and a byte-stream loader, e.g. a UART RX.
- On request: halts the core, writes a little-endian word stream into BRAM from address 0, then releases the core so it restarts from the new program.
- Port B (instruction fetch) is untouched.

---
 rtl/bram_prog_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_bram_prog_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_prog_loader.sv
// Boot/program-load sequencer: owns the core reset and muxes BRAM port A between core dmem and a byte-stream loader.
// Optional inter-byte timeout abort is compiled in when LOADER_TIMEOUT_EN is defined.
module bram_prog_loader #(
    parameter int ADDR_WIDTH      = 10,
    parameter int RST_HOLD_CYCLES = 6,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_load_words,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [31:0]           i_core_wr_data,
    input  logic [3:0]            i_core_wr_en,
    output logic [31:0]           o_core_rd_data,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [31:0]           o_bram_wr_data,
    output logic [3:0]            o_bram_wr_en,
    input  logic [31:0]           i_bram_rd_data,
    output logic                  o_core_reset,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic                  o_err
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    if (RST_HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("bram_prog_loader: RST_HOLD_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT,
        ST_RECV,
        ST_WRITE,
        ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic                  core_reset_q, core_reset_d;
    logic                  busy_q, busy_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  load_done_q, load_done_d;
    logic                  err_q, err_d;
    logic                  rx_accept;
    logic [ADDR_WIDTH:0]   word_cnt_inc;

`ifdef LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0]     idle_q, idle_d;
`endif

    // rx_ready_q is only ever set while in RECV, so it doubles as the state qualifier.
    assign rx_accept    = i_rx_valid & rx_ready_q;
    assign word_cnt_inc = word_cnt_q + 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_d[8*gi +: 8] = (rx_accept && byte_idx_q == 2'(gi)) ? i_rx_data
                                                                        : word_q[8*gi +: 8];
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        word_cnt_d   = word_cnt_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        rx_ready_d   = rx_ready_q;
        load_done_d  = 1'b0;
        err_d        = err_q;
`ifdef LOADER_TIMEOUT_EN
        idle_d       = idle_q;
`endif
        case (state_q)
            ST_BOOT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    hold_d       = '0;
                    core_reset_d = 1'b0;
                    busy_d       = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_start) begin
                    state_d      = ST_HALT;
                    hold_d       = '0;
                    core_reset_d = 1'b1;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    word_cnt_d   = '0;
                    byte_idx_d   = '0;
                    count_d      = (i_load_words > MAX_WORDS) ? MAX_WORDS : i_load_words;
                end
            end
            ST_HALT: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (count_q == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d    = ST_RECV;
                        rx_ready_d = 1'b1;
`ifdef LOADER_TIMEOUT_EN
                        idle_d     = '0;
`endif
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RECV: begin
                if (rx_accept) begin
                    byte_idx_d = byte_idx_q + 1'b1;
`ifdef LOADER_TIMEOUT_EN
                    idle_d     = '0;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d    = ST_WRITE;
                        rx_ready_d = 1'b0;
                    end
                end
`ifdef LOADER_TIMEOUT_EN
                else if (idle_q == IDLE_LAST) begin
                    state_d    = ST_RELEASE;
                    rx_ready_d = 1'b0;
                    err_d      = 1'b1;
                    idle_d     = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_inc;
                byte_idx_d = '0;
                if (word_cnt_inc == count_q) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d    = ST_RECV;
                    rx_ready_d = 1'b1;
`ifdef LOADER_TIMEOUT_EN
                    idle_d     = '0;
`endif
                end
            end
            ST_RELEASE: begin
                state_d      = ST_RUN;
                core_reset_d = 1'b0;
                busy_d       = 1'b0;
                load_done_d  = ~err_q;
            end
            default: begin
                state_d      = ST_BOOT;
                hold_d       = '0;
                core_reset_d = 1'b1;
                busy_d       = 1'b1;
                rx_ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            hold_q       <= '0;
            word_cnt_q   <= '0;
            count_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            rx_ready_q   <= 1'b0;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            word_cnt_q   <= word_cnt_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            rx_ready_q   <= rx_ready_d;
            load_done_q  <= load_done_d;
            err_q        <= err_d;
`ifdef LOADER_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    // Port A: core owns it only in RUN; otherwise the loader drives it and core enables are dropped.
    always_comb begin
        if (state_q == ST_RUN) begin
            o_bram_addr    = i_core_addr;
            o_bram_wr_data = i_core_wr_data;
            o_bram_wr_en   = i_core_wr_en;
        end else begin
            o_bram_addr    = word_cnt_q[ADDR_WIDTH-1:0];
            o_bram_wr_data = word_q;
            o_bram_wr_en   = (state_q == ST_WRITE) ? 4'hF : 4'h0;
        end
    end

    assign o_core_rd_data = i_bram_rd_data;
    assign o_rx_ready     = rx_ready_q;
    assign o_core_reset   = core_reset_q;
    assign o_busy         = busy_q;
    assign o_load_done    = load_done_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_bram_prog_loader.sv
// Self-checking bench for bram_prog_loader: random byte streams checked against an expected word list.
module tb_bram_prog_loader;

    localparam int AW   = 4;
    localparam int HOLD = 6;
    localparam int TO   = 50;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_load_words = '0;
    logic [7:0]    i_rx_data = '0;
    logic          i_rx_valid = 1'b0;
    logic          o_rx_ready;
    logic [AW-1:0] i_core_addr = '0;
    logic [31:0]   i_core_wr_data = '0;
    logic [3:0]    i_core_wr_en = '0;
    logic [31:0]   o_core_rd_data;
    logic [AW-1:0] o_bram_addr;
    logic [31:0]   o_bram_wr_data;
    logic [3:0]    o_bram_wr_en;
    logic [31:0]   i_bram_rd_data = '0;
    logic          o_core_reset;
    logic          o_busy;
    logic          o_load_done;
    logic          o_err;

    always #5 clk = ~clk;

    bram_prog_loader #(
        .ADDR_WIDTH(AW),
        .RST_HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_load_words(i_load_words),
        .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid),
        .o_rx_ready(o_rx_ready),
        .i_core_addr(i_core_addr),
        .i_core_wr_data(i_core_wr_data),
        .i_core_wr_en(i_core_wr_en),
        .o_core_rd_data(o_core_rd_data),
        .o_bram_addr(o_bram_addr),
        .o_bram_wr_data(o_bram_wr_data),
        .o_bram_wr_en(o_bram_wr_en),
        .i_bram_rd_data(i_bram_rd_data),
        .o_core_reset(o_core_reset),
        .o_busy(o_busy),
        .o_load_done(o_load_done),
        .o_err(o_err)
    );

    int checks = 0;
    int passed = 0;

    // Write log and event counters gathered on the falling edge while mon_en is set.
    logic          mon_en = 1'b0;
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    logic [3:0]    log_en[$];
    int done_pulses, rdy_seen, reset_low_busy, busy_cycles;
    logic [7:0]    byte_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_bram_wr_en != 4'h0) begin
                log_addr.push_back(o_bram_addr);
                log_data.push_back(o_bram_wr_data);
                log_en.push_back(o_bram_wr_en);
            end
            if (o_load_done) done_pulses++;
            if (o_rx_ready) rdy_seen++;
            if (o_busy) begin
                busy_cycles++;
                if (!o_core_reset) reset_low_busy++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        log_addr.delete();
        log_data.delete();
        log_en.delete();
        done_pulses = 0;
        rdy_seen = 0;
        reset_low_busy = 0;
        busy_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax, output bit ok);
        logic rdy;
        repeat ($urandom_range(0, gapmax)) tick();
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            rdy = o_rx_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    // Counts falling edges with o_core_reset high after reset_n rises; busy must track it.
    task automatic count_boot(output int hi, output int skew);
        hi = 0;
        skew = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (o_busy !== o_core_reset) skew++;
            if (o_core_reset) hi++;
            else break;
        end
    endtask

    task automatic test_reset();
        int hi, skew;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({o_core_reset, o_busy, o_rx_ready, o_load_done, o_err} !== 5'b11000)
            $display("FAIL reset_values got=%b want=11000",
                     {o_core_reset, o_busy, o_rx_ready, o_load_done, o_err});
        else passed++;
        reset_n = 1'b1;
        count_boot(hi, skew);
        checks++;
        if (hi !== HOLD) $display("FAIL boot_hold got=%0d want=%0d", hi, HOLD);
        else passed++;
        checks++;
        if (skew !== 0) $display("FAIL boot_busy_skew got=%0d want=0", skew);
        else passed++;
        $display("test_reset: boot hold %0d cycles", hi);
    endtask

    task automatic test_passthrough();
        logic [AW-1:0] a;
        logic [31:0]   d, r;
        logic [3:0]    e;
        tick();
        for (int v = 0; v < 5; v++) begin
            if (v == 0) begin
                a = AW'(5); e = 4'b0011; d = 32'hAABBCCDD; r = 32'h11223344;
            end else begin
                a = AW'($urandom); e = 4'($urandom); d = $urandom; r = $urandom;
            end
            i_core_addr = a; i_core_wr_en = e; i_core_wr_data = d; i_bram_rd_data = r;
            i_rx_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({o_bram_addr, o_bram_wr_en, o_bram_wr_data} !== {a, e, d})
                $display("FAIL pass_portA got=%h/%h/%h want=%h/%h/%h",
                         o_bram_addr, o_bram_wr_en, o_bram_wr_data, a, e, d);
            else passed++;
            checks++;
            if (o_core_rd_data !== r) $display("FAIL pass_rd got=%h want=%h", o_core_rd_data, r);
            else passed++;
            checks++;
            if ({o_rx_ready, o_core_reset, o_busy} !== 3'b000)
                $display("FAIL pass_ctrl got=%b want=000", {o_rx_ready, o_core_reset, o_busy});
            else passed++;
            $display("passthrough: addr=%h en=%h data=%h rd=%h", a, e, d, r);
            tick();
        end
        i_core_addr = '0; i_core_wr_en = '0; i_core_wr_data = '0; i_rx_valid = 1'b0;
    endtask

    // Runs one load of n words using byte_q and checks the BRAM writes against the expected word list.
    task automatic run_load(input int n, input int gapmax, input bit noise, input bit restart,
                            input string tag);
        int eff;
        bit ok, all_ok, fell;
        logic [31:0] w;
        eff = (n > MAXW) ? MAXW : n;
        clear_mon();
        mon_en = 1'b1;
        i_start = 1'b1;
        i_load_words = n[AW:0];
        tick();
        i_start = 1'b0;
        if (noise) begin
            i_core_wr_en = 4'hF;
            i_core_addr = AW'($urandom);
            i_core_wr_data = $urandom;
        end
        all_ok = 1'b1;
        for (int i = 0; i < eff * 4; i++) begin
            if (restart && i == 1) begin
                i_start = 1'b1;
                i_load_words = (AW+1)'(1);
            end
            if (restart && i == 5) i_start = 1'b0;
            send_byte(byte_q[i], gapmax, ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
        end
        i_start = 1'b0;
        i_core_wr_en = '0;
        fell = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!o_busy) begin
                fell = 1'b1;
                break;
            end
        end
        tick();
        tick();
        mon_en = 1'b0;
        @(negedge clk);
        checks++;
        if (!all_ok) $display("FAIL %s bytes_accepted got=0 want=1", tag);
        else passed++;
        checks++;
        if (!fell) $display("FAIL %s busy_fall got=timeout want=released", tag);
        else passed++;
        checks++;
        if (log_addr.size() !== eff)
            $display("FAIL %s write_count got=%0d want=%0d", tag, log_addr.size(), eff);
        else passed++;
        for (int i = 0; i < eff && i < log_addr.size(); i++) begin
            w = {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
            checks++;
            if ({log_addr[i], log_en[i], log_data[i]} !== {AW'(i), 4'hF, w})
                $display("FAIL %s write%0d got=%h/%h/%h want=%h/f/%h", tag, i,
                         log_addr[i], log_en[i], log_data[i], AW'(i), w);
            else passed++;
        end
        checks++;
        if (done_pulses !== 1) $display("FAIL %s done_pulses got=%0d want=1", tag, done_pulses);
        else passed++;
        checks++;
        if (reset_low_busy !== 0)
            $display("FAIL %s core_reset_low_while_busy got=%0d want=0", tag, reset_low_busy);
        else passed++;
        checks++;
        if ({o_core_reset, o_busy, o_err} !== 3'b000)
            $display("FAIL %s end_state got=%b want=000", tag, {o_core_reset, o_busy, o_err});
        else passed++;
        if (eff == 0) begin
            checks++;
            if (rdy_seen !== 0) $display("FAIL %s rx_ready_seen got=%0d want=0", tag, rdy_seen);
            else passed++;
            checks++;
            if (busy_cycles !== HOLD + 1)
                $display("FAIL %s busy_cycles got=%0d want=%0d", tag, busy_cycles, HOLD + 1);
            else passed++;
        end
        $display("%s: n=%0d words=%0d writes=%0d done=%0d", tag, n, eff, log_addr.size(),
                 done_pulses);
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic test_spec_load();
        byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(2, 3, 1'b0, 1'b0, "test_spec_load");
    endtask

    task automatic test_zero_load();
        byte_q.delete();
        run_load(0, 0, 1'b0, 1'b0, "test_zero_load");
    endtask

    task automatic test_noise_restart();
        fill_random(12);
        run_load(3, 2, 1'b1, 1'b1, "test_noise_restart");
    endtask

    task automatic test_random_loads();
        int n;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 5);
            fill_random(n * 4);
            run_load(n, 4, 1'(k & 1), 1'b0, "test_random_load");
        end
    endtask

    task automatic test_clamp();
        fill_random(MAXW * 4);
        run_load(MAXW + 4, 0, 1'b0, 1'b0, "test_clamp");
    endtask

`ifdef LOADER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, fell;
        logic [31:0] w;
        fill_random(12);
        clear_mon();
        mon_en = 1'b1;
        i_start = 1'b1;
        i_load_words = (AW+1)'(3);
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(byte_q[i], 2, ok);
        repeat (TO - 5) @(negedge clk);
        checks++;
        if ({o_err, o_busy} !== 2'b01)
            $display("FAIL timeout_early got=%b want=01", {o_err, o_busy});
        else passed++;
        fell = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (!o_busy) begin
                fell = 1'b1;
                break;
            end
        end
        tick();
        mon_en = 1'b0;
        @(negedge clk);
        w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
        checks++;
        if ({fell, o_err, o_core_reset} !== 3'b110)
            $display("FAIL timeout_abort got=%b want=110", {fell, o_err, o_core_reset});
        else passed++;
        checks++;
        if (done_pulses !== 0) $display("FAIL timeout_done got=%0d want=0", done_pulses);
        else passed++;
        checks++;
        if (log_addr.size() !== 1 || log_data[0] !== w || log_addr[0] !== '0)
            $display("FAIL timeout_writes got=%0d want=1 (word %h)", log_addr.size(), w);
        else passed++;
        tick();
        i_start = 1'b1;
        i_load_words = '0;
        tick();
        i_start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) $display("FAIL timeout_err_clear got=%b want=0", o_err);
        else passed++;
        repeat (HOLD + 4) tick();
        $display("test_timeout: writes=%0d err cleared by restart", log_addr.size());
    endtask
`endif

    task automatic test_reset_mid_load();
        bit ok;
        int hi, skew;
        fill_random(12);
        i_start = 1'b1;
        i_load_words = (AW+1)'(3);
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(byte_q[i], 1, ok);
        i_rx_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({o_core_reset, o_busy, o_rx_ready, o_load_done, o_err} !== 5'b11000)
            $display("FAIL midload_reset got=%b want=11000",
                     {o_core_reset, o_busy, o_rx_ready, o_load_done, o_err});
        else passed++;
        i_rx_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        count_boot(hi, skew);
        checks++;
        if (hi !== HOLD || skew !== 0)
            $display("FAIL midload_reboot got=%0d/%0d want=%0d/0", hi, skew, HOLD);
        else passed++;
        $display("test_reset_mid_load: reboot hold %0d cycles", hi);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_spec_load();
        test_zero_load();
        test_noise_restart();
        test_random_loads();
        test_clamp();
`ifdef LOADER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
